// File: rtl/bsg_arb_rr_hold_one_hot.sv
// Registered round-robin arbiter with a held one-hot grant and valid/yumi handshake.
// Priority is lowest-index-first, rotated past the last accepted requester. A grant
// stays fixed until yumi_i, so downstream one-hot muxes see a stable select.
// Optional feature: define BSG_ARB_RR_HOLD_TAG_EN to add a registered binary index
// of the grant on tag_o.

`ifdef BSG_ARB_RR_HOLD_TAG_EN
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif
`endif

module bsg_arb_rr_hold_one_hot #(
    // Instantiators must set this; the default only lets the block elaborate on its own.
    parameter int unsigned width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] reqs_i,
    input  logic               yumi_i,
    output logic [width_p-1:0] grants_o,
    output logic               v_o
`ifdef BSG_ARB_RR_HOLD_TAG_EN
    ,
    output logic [`BSG_SAFE_CLOG2(width_p)-1:0] tag_o
`endif
);

    localparam logic [width_p-1:0] one_lp      = width_p'(1);
    // Pointer reset to the top bit so the first scan starts at bit 0.
    localparam logic [width_p-1:0] last_rst_lp = one_lp << (width_p - 1);

    logic [width_p-1:0] grants_q, grants_d;
    logic [width_p-1:0] last_q, last_d;
    logic               hold;
    logic               accept;

    // Pick the first set request strictly above the pointer, else wrap to the lowest
    // set request overall. Equivalent to rotate / lo_to_hi scan / edge detect / un-rotate.
    function automatic logic [width_p-1:0] rr_select(input logic [width_p-1:0] reqs,
                                                     input logic [width_p-1:0] ptr);
        logic [width_p-1:0] upper;
        logic [width_p-1:0] pick;
        upper = reqs & ~(ptr | (ptr - one_lp));
        pick  = (upper != '0) ? upper : reqs;
        return pick & (~pick + one_lp);
    endfunction

    assign hold   = |grants_q;
    // yumi_i with no valid grant is ignored entirely.
    assign accept = hold & yumi_i;

    // Next-state: load in IDLE, hold in HOLD, advance pointer and reselect on accept.
    always_comb begin
        grants_d = grants_q;
        last_d   = last_q;
        if (!hold) begin
            grants_d = rr_select(reqs_i, last_q);
        end else if (accept) begin
            last_d   = grants_q;
            grants_d = rr_select(reqs_i, grants_q);
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            grants_q <= '0;
            last_q   <= last_rst_lp;
        end else begin
            grants_q <= grants_d;
            last_q   <= last_d;
        end
    end

    assign grants_o = grants_q;
    assign v_o      = hold;

`ifdef BSG_ARB_RR_HOLD_TAG_EN
    localparam int unsigned tag_width_lp = `BSG_SAFE_CLOG2(width_p);

    logic [tag_width_lp-1:0] tag_q, tag_d;

    // Binary index of the next grant; zero when no grant.
    always_comb begin
        tag_d = '0;
        for (int unsigned i = 0; i < width_p; i++) begin
            if (grants_d[i]) tag_d = tag_width_lp'(i);
        end
    end

    // Tag register, updated on the same edge as the grant.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_o = tag_q;
`endif

endmodule

// File: tb/tb_bsg_arb_rr_hold_one_hot.sv
// Directed, table-driven bench for bsg_arb_rr_hold_one_hot (width_p=4 and width_p=1).

module tb_bsg_arb_rr_hold_one_hot;

    typedef struct {
        logic       rst;
        logic [3:0] reqs;
        logic       yumi;
        logic [3:0] exp_grants;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] reqs;
    logic       yumi;
    logic [3:0] grants;
    logic       v;

    logic       reset1;
    logic [0:0] reqs1;
    logic       yumi1;
    logic [0:0] grants1;
    logic       v1;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BSG_ARB_RR_HOLD_TAG_EN
    logic [1:0] tag;
    logic [0:0] tag1;
`endif

    always #5 clk = ~clk;

    bsg_arb_rr_hold_one_hot #(.width_p(4)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .reqs_i  (reqs),
        .yumi_i  (yumi),
        .grants_o(grants),
        .v_o     (v)
`ifdef BSG_ARB_RR_HOLD_TAG_EN
        ,
        .tag_o   (tag)
`endif
    );

    bsg_arb_rr_hold_one_hot #(.width_p(1)) dut1 (
        .clk_i   (clk),
        .reset_i (reset1),
        .reqs_i  (reqs1),
        .yumi_i  (yumi1),
        .grants_o(grants1),
        .v_o     (v1)
`ifdef BSG_ARB_RR_HOLD_TAG_EN
        ,
        .tag_o   (tag1)
`endif
    );

    task automatic check(input string name, input int idx, input logic [3:0] act,
                         input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, req);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [3:0] prev;

        reset  = 1'b1;
        reqs   = 4'b0000;
        yumi   = 1'b0;
        reset1 = 1'b1;
        reqs1  = 1'b0;
        yumi1  = 1'b0;

        // {reset, reqs, yumi, grants expected after the edge}
        vecs.push_back('{1'b1, 4'b1111, 1'b0, 4'b0000});  // reset dominates requests
        vecs.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000});  // reset dominates yumi
        vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0001});  // first grant bit 0
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010});  // round robin
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001});  // wrap
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b0, 4'b0101, 1'b0, 4'b0001});  // held, no preemption
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 4'b0001});  // sticky after request drops
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000});  // accept, nothing pending
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000});  // idle
        vecs.push_back('{1'b0, 4'b1000, 1'b0, 4'b1000});  // scan from bit 1 finds bit 3
        vecs.push_back('{1'b0, 4'b1001, 1'b1, 4'b0001});  // accept 1000, wrap to bit 0
        vecs.push_back('{1'b0, 4'b0001, 1'b1, 4'b0001});  // sole requester re-granted
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000});  // pointer now at bit 0
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000});  // illegal yumi while idle
        vecs.push_back('{1'b0, 4'b0011, 1'b1, 4'b0010});  // pointer unchanged: bit 1 wins
        vecs.push_back('{1'b0, 4'b0100, 1'b1, 4'b0100});  // accept 0010 -> 0100
        vecs.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000});  // reset mid-hold
        vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0001});  // priority back at bit 0
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 4'b0010});  // sticky with no requests

        prev = 4'b0000;
        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            reqs  = vecs[i].reqs;
            yumi  = vecs[i].yumi;
            #1;
            // Outputs must not react to inputs before the edge.
            if (i > 0) check("no_comb_path", i, grants, prev);
            @(posedge clk);
            #1;
            check("grants", i, grants, vecs[i].exp_grants);
            check("valid", i, {3'b000, v}, {3'b000, |vecs[i].exp_grants});
`ifdef BSG_ARB_RR_HOLD_TAG_EN
            check("tag", i, {2'b00, tag}, {2'b00, idx_of(vecs[i].exp_grants)});
`endif
            prev = vecs[i].exp_grants;
        end

        // width_p=1: load, hold without yumi, sticky, release on yumi, reload.
        @(negedge clk);
        reset1 = 1'b1;
        reqs1  = 1'b1;
        @(posedge clk);
        #1;
        check("w1_reset", 0, {3'b000, grants1}, 4'b0000);
        @(negedge clk);
        reset1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("w1_hold", i, {3'b000, grants1}, 4'b0001);
            check("w1_valid", i, {3'b000, v1}, 4'b0001);
        end
        @(negedge clk);
        reqs1 = 1'b0;
        @(posedge clk);
        #1;
        check("w1_sticky", 0, {3'b000, grants1}, 4'b0001);
        @(negedge clk);
        yumi1 = 1'b1;
        @(posedge clk);
        #1;
        check("w1_release", 0, {3'b000, grants1}, 4'b0000);
        @(negedge clk);
        reqs1 = 1'b1;
        yumi1 = 1'b0;
        @(posedge clk);
        #1;
        check("w1_reload", 0, {3'b000, grants1}, 4'b0001);
        @(negedge clk);
        yumi1 = 1'b1;
        @(posedge clk);
        #1;
        check("w1_back_to_back", 0, {3'b000, grants1}, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
